// File: rtl/move_key_conditioner.sv
// Direction-key conditioner: per-channel sync + debounce + auto-repeat FSM,
// producing active-low single-cycle move strobes with opposing-direction cancel.

module mkc_channel #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_RATE     = 10000000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_n,
   output logic o_stable,
   output logic o_stb
);
   localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   logic          r_sync1, r_sync2, r_stable, r_stb;
   logic [CW-1:0] r_cnt;
   logic [TW-1:0] r_timer;
   state_t        r_state;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b1;
         r_cnt    <= '0;
         r_timer  <= '0;
         r_state  <= IDLE;
         r_stb    <= 1'b0;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
         // Toggle on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
         if (r_sync2 != r_stable) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_stable <= r_sync2;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end

         r_stb <= 1'b0;
         case (r_state)
            IDLE: if (!r_stable) begin
               r_state <= DELAY;
               r_timer <= TW'(REPEAT_DELAY);
               r_stb   <= 1'b1;
            end
            DELAY, REPEAT: begin
               // Release outranks a coincident timer expiry.
               if (r_stable) begin
                  r_state <= IDLE;
               end else if (r_timer == TW'(1)) begin
                  r_state <= REPEAT;
                  r_timer <= TW'(REPEAT_RATE);
                  r_stb   <= 1'b1;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_stable = r_stable;
   assign o_stb    = r_stb;
endmodule

module move_key_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_RATE     = 10000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up_n,
   input  logic       btn_down_n,
   input  logic       btn_left_n,
   input  logic       btn_right_n,
   output logic       v_up,
   output logic       v_down,
   output logic       h_left,
   output logic       h_right,
   output logic [3:0] held
);
   logic [3:0] w_btn_n, w_stable, w_stb;
   logic [3:0] r_held, r_out;

   assign w_btn_n = {btn_up_n, btn_down_n, btn_left_n, btn_right_n};

   for (genvar i = 0; i < 4; i++) begin : g_ch
      mkc_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_RATE    (REPEAT_RATE)
      ) u_ch (
         .i_clk   (clk),
         .i_rst   (rst),
         .i_btn_n (w_btn_n[i]),
         .o_stable(w_stable[i]),
         .o_stb   (w_stb[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_held <= 4'b0000;
         r_out  <= 4'b1111;
      end else begin
         r_held <= ~w_stable;
         // Channel pairs {3,2} and {1,0} are opposing directions.
         r_out[3] <= ~(w_stb[3] & ~w_stb[2]);
         r_out[2] <= ~(w_stb[2] & ~w_stb[3]);
         r_out[1] <= ~(w_stb[1] & ~w_stb[0]);
         r_out[0] <= ~(w_stb[0] & ~w_stb[1]);
      end
   end

   assign {v_up, v_down, h_left, h_right} = r_out;
   assign held = r_held;
endmodule

// File: doc/move_key_conditioner.md
Name: move_key_conditioner

Overview:
- Upstream of the player sprite stage.
- Turns the four raw, bouncy, active-low direction buttons into clean single-cycle active-low move strobes for the player position logic.
- Per channel: 2-FF synchroniser, debouncer, and a hold-to-auto-repeat state machine.
- Strobe outputs connect directly to the player stage's v_up/v_down/h_left/h_right inputs, so each press yields exactly one position step, plus timed repeats while held.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- REPEAT_DELAY, 50000000: cycles from the first strobe to the first auto-repeat strobe.
- REPEAT_RATE, 10000000: cycles between subsequent auto-repeat strobes.
- Counter widths are derived by $clog2 of the largest value used; no truncation is permitted.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  synchronous reset, active-high.
- btn_up_n  input  1  raw up button, active-low, asynchronous.
- btn_down_n  input  1  raw down button, active-low, asynchronous.
- btn_left_n  input  1  raw left button, active-low, asynchronous.
- btn_right_n  input  1  raw right button, active-low, asynchronous.
- v_up  output  1  up move strobe, active-low, one cycle wide.
- v_down  output  1  down move strobe, active-low, one cycle wide.
- h_left  output  1  left move strobe, active-low, one cycle wide.
- h_right  output  1  right move strobe, active-low, one cycle wide.
- held  output  4  debounced pressed state, active-high, ordered {up,down,left,right}.

Behaviour:
- Clocking/reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - Synchroniser flops = 1.
  - Stable levels = 1 (released).
  - All counters = 0.
  - All FSMs = IDLE.
  - Strobe outputs = 1.
  - held = 4'b0000.
  - Reset takes effect at the first clk edge with rst=1 and overrides everything, including reset asserted mid-operation.
- Synchroniser: 2 flops per channel. The sync output reflects the pin 2 edges after sampling.
- Debounce:
  - Per-channel mismatch counter increments each cycle the sync output differs from the stable level.
  - The counter clears to 0 on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
  - Any bounce shorter than DEBOUNCE_CYCLES produces no change.
- held[i] = ~stable[i], registered.
- FSM per channel: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on stable falling edge (press). Raises an internal strobe and loads the timer with REPEAT_DELAY.
  - DELAY: timer decrements. At expiry: raise strobe, load REPEAT_RATE, go to REPEAT.
  - REPEAT: at each timer expiry, raise strobe and reload REPEAT_RATE.
  - DELAY or REPEAT -> IDLE in the same cycle the stable level returns to 1. No strobe on release. If release coincides with a timer expiry, release wins and no strobe is raised.
- Output stage:
  - Strobes are registered and inverted onto the active-low outputs.
  - Each output is low for exactly one cycle per internal strobe.
- Latency: the first strobe goes low DEBOUNCE_CYCLES+3 rising edges after the first edge at which the pin is sampled low. This is exact.
- Opposing-direction cancel:
  - If the up and down internal strobes coincide, neither output asserts in that cycle.
  - The same rule applies to left and right.
  - FSMs and timers are unaffected by the cancel.
  - Orthogonal pairs (e.g. up+right) assert together.
- No interaction between channels other than the cancel rule.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8. Cycle numbers are relative to the first edge sampling the pin low.
- Clean hold: btn_right_n low for cycles 0..39, then high.
  - h_right low exactly at cycles 7, 27, 35, 43.
  - No further strobes.
  - held[0]=1 from cycle 6 until cycle 46.
- Bounce: btn_up_n low for 3 cycles, then high.
  - No strobe on v_up.
  - held stays 0.
  - Mismatch counter back to 0.
- Release during DELAY: btn_left_n low for cycles 0..14.
  - h_left low only at cycle 7.
  - FSM back in IDLE by cycle 21.
  - No repeat strobe at 27.
- Opposing cancel: btn_up_n and btn_down_n low on the same cycle and held.
  - v_up and v_down stay 1 throughout.
  - held = 4'b1100 from cycle 6.
- Orthogonal pair: btn_up_n and btn_right_n low together.
  - v_up and h_right both low at cycle 7 and at cycle 27.
- Reset mid-repeat: btn_left_n held low; rst=1 at cycles 30-31.
  - h_left=1 and held=0 from edge 30.
  - Next strobe at 7 edges after the first edge with rst=0 (cycle 39); no strobe at 35.
